register_file_mp: RTL and testbench

Parametrised multi-port general register file, successor to the fixed 1R1W, 2R1W and 3R2W register files. Read ports, write ports, depth, width, register-zero behaviour and write-to-read bypass are all set by parameters. It adds a serial scan engine on the functional clock, so a debug or JTAG controller can capture, shift out and optionally overwrite any one register. It sits in the execute stage as the general or segment register file and is also exposed to the debug chain.

---
 rtl/register_file_mp.sv | 117 +++++++++++
 tb/tb_register_file_mp.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file with optional zero register and write bypass,
// plus a serial scan engine that can capture, shift out and overwrite one register.
module register_file_mp #(
  parameter int SIZE        = 16,
  parameter int WORD_LENGTH = 32,
  parameter int WIDTH       = WORD_LENGTH,
  parameter int RD_PORTS    = 3,
  parameter int WR_PORTS    = 2,
  parameter int ZERO_REG    = 1,
  parameter int BYPASS      = 1,
  localparam int AW         = $clog2(SIZE),
  localparam int CW         = $clog2(WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [RD_PORTS*AW-1:0]       readAddr,
  output logic [RD_PORTS*WIDTH-1:0]    readData,
  input  logic [WR_PORTS-1:0]          writeEnable,
  input  logic [WR_PORTS*AW-1:0]       writeAddr,
  input  logic [WR_PORTS*WIDTH-1:0]    writeData,
  input  logic                         sStart,
  input  logic                         sWrite,
  input  logic [AW-1:0]                sAddr,
  input  logic                         sIn,
  output logic                         sOut,
  output logic                         sBusy,
  output logic                         sDone
);

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} scanState_t;

  scanState_t        state, nextState;
  logic [WIDTH-1:0]  regFile [SIZE];
  logic [WIDTH-1:0]  shift;
  logic [CW-1:0]     count;
  logic [AW-1:0]     latchAddr;
  logic              latchWrite;
  logic              scanWe;

  assign scanWe = (state == UPDATE) && latchWrite;
  assign sOut   = shift[0];
  assign sBusy  = (state != IDLE);

  // Later ports override earlier ones in the bypass search so port 0 has the final say.
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
    assign a = readAddr[p*AW +: AW];
    always_comb begin
      d = regFile[a];
      if (BYPASS != 0) begin
        if (scanWe && (latchAddr == a)) d = shift;
        for (int w = WR_PORTS-1; w >= 0; w--) begin
          if (writeEnable[w] && (writeAddr[w*AW +: AW] == a)) d = writeData[w*WIDTH +: WIDTH];
        end
      end
      if ((ZERO_REG != 0) && (a == '0)) d = '0;
    end
    assign readData[p*WIDTH +: WIDTH] = d;
  end

  // Scan write-back is issued first so any functional write to the same address lands over it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < SIZE; r++) regFile[r] <= '0;
    end else begin
      if (scanWe && !((ZERO_REG != 0) && (latchAddr == '0))) regFile[latchAddr] <= shift;
      for (int w = WR_PORTS-1; w >= 0; w--) begin
        if (writeEnable[w] && !((ZERO_REG != 0) && (writeAddr[w*AW +: AW] == '0)))
          regFile[writeAddr[w*AW +: AW]] <= writeData[w*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (sStart) nextState = SHIFT;
      SHIFT:   if (count == CW'(WIDTH-1)) nextState = UPDATE;
      UPDATE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift      <= '0;
      count      <= '0;
      latchAddr  <= '0;
      latchWrite <= 1'b0;
      sDone      <= 1'b0;
    end else begin
      sDone <= (state == UPDATE);
      case (state)
        IDLE: begin
          if (sStart) begin
            latchAddr  <= sAddr;
            latchWrite <= sWrite;
            shift      <= regFile[sAddr];
            count      <= '0;
          end
        end
        SHIFT: begin
          shift <= {sIn, shift[WIDTH-1:1]};
          count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp at its default parameters (16x32, 3R2W, zero reg, bypass).
module tb_register_file_mp;

  localparam int AW = 4;
  localparam int W  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [3*AW-1:0] readAddr;
  logic [3*W-1:0]  readData;
  logic [1:0]      writeEnable;
  logic [2*AW-1:0] writeAddr;
  logic [2*W-1:0]  writeData;
  logic            sStart, sWrite, sIn;
  logic [AW-1:0]   sAddr;
  logic            sOut, sBusy, sDone;

  int compared = 0;
  int mismatched = 0;

  register_file_mp dut (
    .clk(clk), .rst(rst),
    .readAddr(readAddr), .readData(readData),
    .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData),
    .sStart(sStart), .sWrite(sWrite), .sAddr(sAddr), .sIn(sIn),
    .sOut(sOut), .sBusy(sBusy), .sDone(sDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we0; logic [AW-1:0] wa0; logic [W-1:0] wd0;
    logic          we1; logic [AW-1:0] wa1; logic [W-1:0] wd1;
    logic [AW-1:0] ra0, ra1, ra2;
    logic [W-1:0]  e0, e1, e2;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    writeEnable = {v.we1, v.we0};
    writeAddr   = {v.wa1, v.wa0};
    writeData   = {v.wd1, v.wd0};
    readAddr    = {v.ra2, v.ra1, v.ra0};
  endtask

  task automatic idleFunc();
    writeEnable = 2'b00;
    writeAddr   = '0;
    writeData   = '0;
  endtask

  task automatic readReg(input logic [AW-1:0] a, input string name, input logic [W-1:0] exp);
    readAddr[AW-1:0] = a;
    #1;
    checkOutput(name, readData[W-1:0], exp);
  endtask

  task automatic startScan(input logic [AW-1:0] a, input logic wr);
    sStart = 1'b1; sAddr = a; sWrite = wr;
    tick();
    sStart = 1'b0;
  endtask

  logic [W-1:0] pat;
  logic [W-1:0] val;
  int doneSeen;

  initial begin
    //               we0 wa0 wd0           we1 wa1 wd1           ra0 ra1 ra2  e0            e1            e2
    vecs[0] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,        4'd5, 4'd0, 4'd1,  32'h0,        32'h0,        32'h0};
    vecs[1] = '{1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0,        4'd5, 4'd4, 4'd6,  32'hDEADBEEF, 32'h0,        32'h0};
    vecs[2] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,        4'd5, 4'd0, 4'd15, 32'hDEADBEEF, 32'h0,        32'h0};
    vecs[3] = '{1'b1, 4'd3, 32'h11111111, 1'b1, 4'd3, 32'h22222222, 4'd3, 4'd5, 4'd2,  32'h11111111, 32'hDEADBEEF, 32'h0};
    vecs[4] = '{1'b1, 4'd0, 32'hAAAA5555, 1'b1, 4'd0, 32'h12121212, 4'd0, 4'd3, 4'd0,  32'h0,        32'h11111111, 32'h0};
    vecs[5] = '{1'b1, 4'd9, 32'hCAFEF00D, 1'b1, 4'd7, 32'hA5A5A5A5, 4'd7, 4'd9, 4'd3,  32'hA5A5A5A5, 32'hCAFEF00D, 32'h11111111};
    vecs[6] = '{1'b1, 4'd9, 32'h0,        1'b0, 4'd0, 32'h0,        4'd9, 4'd7, 4'd0,  32'h0,        32'hA5A5A5A5, 32'h0};
    vecs[7] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,        4'd9, 4'd7, 4'd3,  32'h0,        32'hA5A5A5A5, 32'h11111111};

    rst = 1'b1; sStart = 1'b0; sWrite = 1'b0; sAddr = '0; sIn = 1'b0;
    readAddr = '0; idleFunc();
    tick();
    rst = 1'b0;
    checkOutput("reset sBusy", {31'b0, sBusy}, 32'h0);
    checkOutput("reset sDone", {31'b0, sDone}, 32'h0);
    checkOutput("reset sOut",  {31'b0, sOut},  32'h0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d rd0", i), readData[0*W +: W], vecs[i].e0);
      checkOutput($sformatf("vec%0d rd1", i), readData[1*W +: W], vecs[i].e1);
      checkOutput($sformatf("vec%0d rd2", i), readData[2*W +: W], vecs[i].e2);
      tick();
    end
    idleFunc();

    // Read-only scan of r7; sIn held high must not leak into the register.
    pat = 32'hA5A5A5A5;
    sIn = 1'b1;
    startScan(4'd7, 1'b0);
    for (int i = 0; i < W; i++) begin
      checkOutput($sformatf("ro sOut bit%0d", i), {31'b0, sOut}, {31'b0, pat[i]});
      checkOutput($sformatf("ro sBusy %0d", i), {31'b0, sBusy}, 32'h1);
      tick();
    end
    checkOutput("ro sDone in UPDATE", {31'b0, sDone}, 32'h0);
    tick();
    checkOutput("ro sDone pulse", {31'b0, sDone}, 32'h1);
    checkOutput("ro sBusy after", {31'b0, sBusy}, 32'h0);
    tick();
    checkOutput("ro sDone cleared", {31'b0, sDone}, 32'h0);
    readReg(4'd7, "ro r7 unchanged", 32'hA5A5A5A5);

    // Write-back scan into r9 with sStart pulses (other addr, read-only) during SHIFT.
    val = 32'h12345678;
    startScan(4'd9, 1'b1);
    for (int k = 1; k <= W; k++) begin
      sIn = val[k-1];
      if (k == 5 || k == 20) begin
        sStart = 1'b1; sAddr = 4'd3; sWrite = 1'b0;
      end else begin
        sStart = 1'b0;
      end
      tick();
    end
    sStart = 1'b0;
    checkOutput("wb busy before UPDATE", {31'b0, sBusy}, 32'h1);
    tick();
    checkOutput("wb sBusy after", {31'b0, sBusy}, 32'h0);
    checkOutput("wb sDone pulse", {31'b0, sDone}, 32'h1);
    readReg(4'd9, "wb r9", 32'h12345678);
    readReg(4'd3, "lockout r3", 32'h11111111);
    tick();
    checkOutput("wb sDone one cycle", {31'b0, sDone}, 32'h0);
    checkOutput("lockout no restart", {31'b0, sBusy}, 32'h0);

    // Functional write in the UPDATE cycle beats the scan value.
    sAddr = 4'd0;
    val = 32'h0F0F0F0F;
    startScan(4'd9, 1'b1);
    for (int k = 1; k <= W; k++) begin
      sIn = val[k-1];
      tick();
    end
    writeEnable = 2'b01; writeAddr = {4'd0, 4'd9}; writeData = {32'h0, 32'hFFFFFFFF};
    tick();
    idleFunc();
    readReg(4'd9, "update conflict r9", 32'hFFFFFFFF);

    // Abort a write-back scan of r5 mid-SHIFT with reset.
    sIn = 1'b1;
    startScan(4'd5, 1'b1);
    for (int k = 0; k < 10; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort sBusy", {31'b0, sBusy}, 32'h0);
    checkOutput("abort sDone", {31'b0, sDone}, 32'h0);
    checkOutput("abort sOut",  {31'b0, sOut},  32'h0);
    doneSeen = 0;
    for (int k = 0; k < W + 4; k++) begin
      tick();
      if (sDone || sBusy) doneSeen++;
    end
    checkOutput("abort no activity", doneSeen, 32'h0);
    for (int r = 0; r < 16; r++) readReg(r[AW-1:0], $sformatf("abort r%0d", r), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
